// File: rtl/core_dout_arbiter.sv
// Round-robin reader of the per-core nibble FIFOs in the CMP_CLK domain.
// Assembles fixed-length records, hands them downstream over valid/ready, and aborts stalled records on timeout.
module core_dout_arbiter #(
  parameter int unsigned N_CORES = 4,
  parameter int unsigned NIBBLES = 8,
  parameter int unsigned TIMEOUT = 255,
  localparam int unsigned CORE_NUM_W = (N_CORES < 2) ? 1 : $clog2(N_CORES)
) (
  input  logic                  CLK,
  input  logic                  rst_n,
  input  logic [4*N_CORES-1:0]  core_dout,
  input  logic [N_CORES-1:0]    core_empty,
  output logic [N_CORES-1:0]    core_rd_en,
  output logic [4*NIBBLES-1:0]  out_data,
  output logic [CORE_NUM_W-1:0] out_core_num,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  err_timeout,
  output logic                  idle
);

  localparam int unsigned DATA_W = 4 * NIBBLES;
  localparam int unsigned ASM_W  = 4 * (NIBBLES - 1);
  localparam int unsigned CNT_W  = $clog2(NIBBLES);
  localparam int unsigned TMR_W  = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0]      LAST_SLOT = CNT_W'(NIBBLES - 1);
  localparam logic [TMR_W-1:0]      TMR_LIMIT = TMR_W'(TIMEOUT - 1);
  localparam logic [CORE_NUM_W-1:0] LAST_CORE = CORE_NUM_W'(N_CORES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CORE_NUM_W-1:0] r_sel;
  logic [CORE_NUM_W-1:0] w_sel_nxt;
  logic [CORE_NUM_W-1:0] r_last_grant;
  logic [CORE_NUM_W-1:0] w_last_grant_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic [TMR_W-1:0]      r_timer;
  logic [TMR_W-1:0]      w_timer_nxt;
  logic [ASM_W-1:0]      r_asm;
  logic [ASM_W-1:0]      w_asm_nxt;
  logic [DATA_W-1:0]     r_data;
  logic [DATA_W-1:0]     w_data_nxt;
  logic [CORE_NUM_W-1:0] r_core_num;
  logic [CORE_NUM_W-1:0] w_core_num_nxt;
  logic                  r_valid;
  logic                  w_valid_nxt;
  logic                  r_err;
  logic                  w_err_nxt;

  logic                  w_found;
  logic [CORE_NUM_W-1:0] w_pick;
  int unsigned           w_idx;
  logic [3:0]            w_nib;
  logic                  w_sel_empty;
  logic [N_CORES-1:0]    w_sel_hot;
  logic [DATA_W-1:0]     w_shift;

  // Round-robin search: first non-empty core starting just after the last grant.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_last_grant;
    w_idx   = 0;
    for (int unsigned k = 1; k <= N_CORES; k++) begin
      w_idx = (32'(r_last_grant) + k) % N_CORES;
      if (!w_found && !core_empty[CORE_NUM_W'(w_idx)]) begin
        w_found = 1'b1;
        w_pick  = CORE_NUM_W'(w_idx);
      end
    end
  end

  // Selected core's nibble, empty flag and one-hot pop position.
  always_comb begin
    w_nib       = 4'h0;
    w_sel_empty = 1'b1;
    w_sel_hot   = '0;
    for (int unsigned i = 0; i < N_CORES; i++) begin
      if (r_sel == CORE_NUM_W'(i)) begin
        w_nib        = core_dout[4*i +: 4];
        w_sel_empty  = core_empty[i];
        w_sel_hot[i] = 1'b1;
      end
    end
  end

  // Earlier nibbles shift toward the MSBs, so the first one popped ends up on top.
  assign w_shift = {r_asm, w_nib};

  // Next-state and datapath updates.
  always_comb begin
    w_state_nxt      = r_state;
    w_sel_nxt        = r_sel;
    w_last_grant_nxt = r_last_grant;
    w_cnt_nxt        = r_cnt;
    w_timer_nxt      = r_timer;
    w_asm_nxt        = r_asm;
    w_data_nxt       = r_data;
    w_core_num_nxt   = r_core_num;
    w_valid_nxt      = r_valid;
    w_err_nxt        = r_err;
    core_rd_en       = '0;

    unique case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_sel_nxt   = w_pick;
          w_cnt_nxt   = '0;
          w_timer_nxt = '0;
          w_state_nxt = S_READ;
        end
      end

      S_READ: begin
        if (!w_sel_empty) begin
          core_rd_en  = w_sel_hot;
          w_asm_nxt   = w_shift[ASM_W-1:0];
          w_timer_nxt = '0;
          if (r_cnt == LAST_SLOT) begin
            w_data_nxt     = w_shift;
            w_core_num_nxt = r_sel;
            w_valid_nxt    = 1'b1;
            w_state_nxt    = S_OUT;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end else if ((TIMEOUT != 0) && (r_timer == TMR_LIMIT)) begin
          // Abandon the partial record; the grant still rotates past this core.
          w_err_nxt        = 1'b1;
          w_last_grant_nxt = r_sel;
          w_state_nxt      = S_IDLE;
        end else begin
          w_timer_nxt = r_timer + TMR_W'(1);
        end
      end

      S_OUT: begin
        if (out_ready) begin
          w_valid_nxt      = 1'b0;
          w_last_grant_nxt = r_sel;
          w_state_nxt      = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath registers; reset discards any record in progress.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_sel        <= '0;
      r_last_grant <= LAST_CORE;
      r_cnt        <= '0;
      r_timer      <= '0;
      r_asm        <= '0;
      r_data       <= '0;
      r_core_num   <= '0;
      r_valid      <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_sel        <= w_sel_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_cnt        <= w_cnt_nxt;
      r_timer      <= w_timer_nxt;
      r_asm        <= w_asm_nxt;
      r_data       <= w_data_nxt;
      r_core_num   <= w_core_num_nxt;
      r_valid      <= w_valid_nxt;
      r_err        <= w_err_nxt;
    end
  end

  assign out_data     = r_data;
  assign out_core_num = r_core_num;
  assign out_valid    = r_valid;
  assign err_timeout  = r_err;
  assign idle         = (r_state == S_IDLE) && (&core_empty);

endmodule

// File: tb/tb_core_dout_arbiter.sv
// Directed bench for core_dout_arbiter: FIFO models per core, handshake log, hand-computed expectations.
// u_dut uses the default timeout; u_dut_to uses TIMEOUT=4 for the abort scenario.
module tb_core_dout_arbiter;

  localparam int unsigned NC = 4;
  localparam int unsigned NB = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [3:0] mem [2][NC][64] = '{default: '0};
  logic [5:0] wp  [2][NC]     = '{default: '0};
  logic [5:0] rp  [2][NC]     = '{default: '0};

  logic [4*NC-1:0] dout0, dout1;
  logic [NC-1:0]   empty0, empty1, rd0, rd1;
  logic [4*NB-1:0] odata0, odata1;
  logic [1:0]      onum0, onum1;
  logic            ovalid0, ovalid1, oready0, oready1, err0, err1, idl0, idl1;

  core_dout_arbiter #(.N_CORES(NC), .NIBBLES(NB), .TIMEOUT(255)) u_dut (
    .CLK(clk), .rst_n(rst_n), .core_dout(dout0), .core_empty(empty0), .core_rd_en(rd0),
    .out_data(odata0), .out_core_num(onum0), .out_valid(ovalid0), .out_ready(oready0),
    .err_timeout(err0), .idle(idl0)
  );

  core_dout_arbiter #(.N_CORES(NC), .NIBBLES(NB), .TIMEOUT(4)) u_dut_to (
    .CLK(clk), .rst_n(rst_n), .core_dout(dout1), .core_empty(empty1), .core_rd_en(rd1),
    .out_data(odata1), .out_core_num(onum1), .out_valid(ovalid1), .out_ready(oready1),
    .err_timeout(err1), .idle(idl1)
  );

  // First-word fall-through FIFO outputs.
  always_comb begin
    for (int c = 0; c < NC; c++) begin
      empty0[c]       = (rp[0][c] == wp[0][c]);
      empty1[c]       = (rp[1][c] == wp[1][c]);
      dout0[4*c +: 4] = mem[0][c][rp[0][c]];
      dout1[4*c +: 4] = mem[1][c][rp[1][c]];
    end
  end

  int          cyc       = 0;
  int          n_log     = 0;
  logic [1:0]  log_num  [32];
  logic [31:0] log_data [32];
  int          log_cyc  [32];
  int          burst    [32];
  int          n_burst   = 0;
  int          run       = 0;
  int          multi_rd  = 0;
  int          rd_in_out = 0;

  // FIFO pops, handshake log and read-burst tracking for u_dut.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int c = 0; c < NC; c++) begin
      if (rd0[c] && !empty0[c]) rp[0][c] <= rp[0][c] + 6'd1;
      if (rd1[c] && !empty1[c]) rp[1][c] <= rp[1][c] + 6'd1;
    end
    if (rst_n) begin
      if (ovalid0 && oready0 && n_log < 32) begin
        log_num[n_log]  <= onum0;
        log_data[n_log] <= odata0;
        log_cyc[n_log]  <= cyc;
        n_log           <= n_log + 1;
      end
      if ($countones(rd0) > 1) multi_rd <= multi_rd + 1;
      if (rd0 != '0 && ovalid0) rd_in_out <= rd_in_out + 1;
      if (rd0 != '0) begin
        run <= run + 1;
      end else if (run != 0) begin
        if (n_burst < 32) burst[n_burst] <= run;
        n_burst <= n_burst + 1;
        run     <= 0;
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Push nibbles lo..hi-1 of rec (index 0 = MSB nibble) into FIFO c of bench side d.
  task automatic push(input int d, input int c, input logic [31:0] rec, input int lo, input int hi);
    for (int k = lo; k < hi; k++) begin
      mem[d][c][wp[d][c]] = rec[31-4*k -: 4];
      wp[d][c] = wp[d][c] + 6'd1;
    end
  endtask

  task automatic flush_all();
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < NC; c++) wp[d][c] = rp[d][c];
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int l0;
    int b0;
    int bad;
    logic [31:0] exp_data [5];
    logic [1:0]  exp_core [5];

    rst_n   = 1'b0;
    oready0 = 1'b0;
    oready1 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_data",  odata0,  32'h0);
    chk("rst_num",   onum0,   32'd0);
    chk("rst_valid", ovalid0, 32'd0);
    chk("rst_rd",    rd0,     32'd0);
    chk("rst_err",   err0,    32'd0);
    chk("rst_idle",  idl0,    32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_rst", idl0, 32'd1);

    // Single record on core 2.
    oready0 = 1'b1;
    push(0, 2, 32'h12345678, 0, 8);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) chk("t1_rd_first", rd0, 32'h4);
    end while (!ovalid0 && n < 200);
    chk("t1_latency", n, 32'd9);
    chk("t1_data", odata0, 32'h12345678);
    chk("t1_core", onum0, 32'd2);
    @(negedge clk);
    chk("t1_valid_drop", ovalid0, 32'd0);

    // All cores loaded, ready held high.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_data[0] = 32'hA0B1C2D3; exp_core[0] = 2'd0;
    exp_data[1] = 32'h13579BDF; exp_core[1] = 2'd1;
    exp_data[2] = 32'h2468ACE0; exp_core[2] = 2'd2;
    exp_data[3] = 32'hFEDCBA98; exp_core[3] = 2'd3;
    exp_data[4] = 32'h0F1E2D3C; exp_core[4] = 2'd0;
    b0 = n_burst;
    l0 = n_log;
    push(0, 0, 32'hA0B1C2D3, 0, 8);
    push(0, 1, 32'h13579BDF, 0, 8);
    push(0, 2, 32'h2468ACE0, 0, 8);
    push(0, 3, 32'hFEDCBA98, 0, 8);
    push(0, 0, 32'h0F1E2D3C, 0, 8);
    for (int i = 0; i < 300 && n_log < l0 + 5; i++) @(negedge clk);
    chk("t2_count", n_log - l0, 32'd5);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t2_core%0d", i), log_num[l0+i], 32'(exp_core[i]));
      chk($sformatf("t2_data%0d", i), log_data[l0+i], exp_data[i]);
      chk($sformatf("t2_burst%0d", i), burst[b0+i], 32'd8);
      if (i > 0) chk($sformatf("t2_gap%0d", i), log_cyc[l0+i] - log_cyc[l0+i-1], 32'd10);
    end

    // Downstream back-pressure during OUT.
    oready0 = 1'b0;
    push(0, 1, 32'h89ABCDEF, 0, 8);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ovalid0 && n < 200);
    chk("t3_latency", n, 32'd9);
    push(0, 2, 32'h55AA33CC, 0, 8);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (odata0 !== 32'h89ABCDEF || onum0 !== 2'd1 || ovalid0 !== 1'b1 || rd0 !== 4'h0) bad++;
    end
    chk("t3_hold", bad, 32'd0);
    chk("t3_core2_level", 32'(6'(wp[0][2] - rp[0][2])), 32'd8);
    l0 = n_log;
    oready0 = 1'b1;
    for (int i = 0; i < 100 && n_log < l0 + 2; i++) @(negedge clk);
    chk("t3_core_a", log_num[l0], 32'd1);
    chk("t3_data_a", log_data[l0], 32'h89ABCDEF);
    chk("t3_core_b", log_num[l0+1], 32'd2);
    chk("t3_data_b", log_data[l0+1], 32'h55AA33CC);

    // Core 1 stalls for 10 cycles after 3 nibbles.
    push(0, 1, 32'hC0FFEE42, 0, 3);
    n = 0;
    repeat (14) begin
      @(negedge clk);
      n++;
      if (n == 10) chk("t4_stalled_rd", rd0, 32'd0);
    end
    push(0, 1, 32'hC0FFEE42, 3, 8);
    do begin
      @(negedge clk);
      n++;
    end while (!ovalid0 && n < 200);
    chk("t4_latency", n, 32'd19);
    chk("t4_data", odata0, 32'hC0FFEE42);
    chk("t4_core", onum0, 32'd1);
    chk("t4_no_err", err0, 32'd0);

    // Timeout abort on the TIMEOUT=4 instance.
    oready1 = 1'b1;
    push(1, 1, 32'h7A500000, 0, 3);
    push(1, 2, 32'h31415926, 0, 8);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 7) chk("t5_err_before", err1, 32'd0);
      if (n == 8) chk("t5_err_set", err1, 32'd1);
    end while (!ovalid1 && n < 200);
    chk("t5_latency", n, 32'd17);
    chk("t5_core", onum1, 32'd2);
    chk("t5_data", odata1, 32'h31415926);
    @(negedge clk);
    chk("t5_err_sticky", err1, 32'd1);
    chk("t5_idle", idl1, 32'd1);

    // Reset in the middle of a record.
    push(0, 2, 32'hDEADBEEF, 0, 8);
    repeat (4) @(negedge clk);
    chk("t6_mid_read", rd0, 32'h4);
    rst_n = 1'b0;
    #1;
    chk("t6_rd_cleared", rd0, 32'd0);
    chk("t6_valid_cleared", ovalid0, 32'd0);
    chk("t6_err_cleared", err1, 32'd0);
    flush_all();
    push(0, 3, 32'h0BADF00D, 0, 8);
    push(0, 0, 32'h600DCAFE, 0, 8);
    l0 = n_log;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 100 && n_log < l0 + 2; i++) @(negedge clk);
    chk("t6_core_a", log_num[l0], 32'd0);
    chk("t6_data_a", log_data[l0], 32'h600DCAFE);
    chk("t6_core_b", log_num[l0+1], 32'd3);
    chk("t6_data_b", log_data[l0+1], 32'h0BADF00D);
    repeat (2) @(negedge clk);
    chk("end_idle", idl0, 32'd1);
    chk("multi_rd", multi_rd, 32'd0);
    chk("rd_during_valid", rd_in_out, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
